// File: rtl/posit_mul_core.sv
// posit_mul_core: iterative shift-add posit significand/scale multiplier, truncating.
// Optional POSIT_MUL_ZERO_EN adds zero-operand flags with a short bypass.
module posit_mul_core #(
    parameter int BITS = 32,
    parameter int ES   = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] a_seed,
    input  logic [ES-1:0]   a_exp,
    input  logic [BITS-1:0] a_frac,
    input  logic [BITS-1:0] b_seed,
    input  logic [ES-1:0]   b_exp,
    input  logic [BITS-1:0] b_frac,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] out_seed,
    output logic [ES-1:0]   out_exp,
    output logic [BITS-1:0] out_frac,
    output logic            out_inexact
`ifdef POSIT_MUL_ZERO_EN
   ,input  logic            a_zero,
    input  logic            b_zero,
    output logic            out_zero
`endif
);
    localparam int N  = BITS + 1;
    localparam int SW = BITS + ES + 2;
    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] NORM = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    logic [N-1:0]    ma;
    logic [N-1:0]    mb;
    logic [2*N-1:0]  acc;
    logic [SW-1:0]   rs;
    logic            zflag;
    logic            skip;
    logic            fire;
    logic [N:0]      sum;
    logic [2*BITS:0] sh;
    logic [SW-1:0]   rs_n;

    function automatic logic [SW-1:0] scale_of(
        input logic [BITS-1:0] seed,
        input logic [ES-1:0]   e
    );
        return ({{(ES+2){seed[BITS-1]}}, seed} << ES) + SW'(e);
    endfunction

`ifdef POSIT_MUL_ZERO_EN
    assign skip = a_zero | b_zero;
`else
    assign skip = 1'b0;
`endif

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign fire      = in_valid && in_ready;

    // Upper half absorbs the partial product, then everything shifts right.
    assign sum  = {1'b0, acc[2*N-1:N]} + (mb[0] ? {1'b0, ma} : '0);
    // Product in [1,4): drop the leading one, keep the bits below it.
    assign sh   = acc[2*N-1] ? acc[2*N-2:0] : {acc[2*N-3:0], 1'b0};
    assign rs_n = rs + SW'(acc[2*N-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            ma          <= '0;
            mb          <= '0;
            acc         <= '0;
            rs          <= '0;
            zflag       <= 1'b0;
            out_seed    <= '0;
            out_exp     <= '0;
            out_frac    <= '0;
            out_inexact <= 1'b0;
`ifdef POSIT_MUL_ZERO_EN
            out_zero    <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (fire) begin
                        ma    <= {1'b1, a_frac};
                        mb    <= {1'b1, b_frac};
                        acc   <= '0;
                        cnt   <= '0;
                        rs    <= scale_of(a_seed, a_exp) + scale_of(b_seed, b_exp);
                        zflag <= skip;
                        state <= skip ? NORM : MUL;
                    end
                end
                MUL: begin
                    acc <= {sum, acc[N-1:1]};
                    mb  <= mb >> 1;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(BITS)) state <= NORM;
                end
                NORM: begin
                    out_seed    <= zflag ? '0 : BITS'($signed(rs_n) >>> ES);
                    out_exp     <= zflag ? '0 : rs_n[ES-1:0];
                    out_frac    <= zflag ? '0 : {sh[2*BITS:BITS+ES+1], {ES{1'b0}}};
                    out_inexact <= zflag ? 1'b0 : |sh[BITS+ES:0];
`ifdef POSIT_MUL_ZERO_EN
                    out_zero    <= zflag;
`endif
                    state       <= DONE;
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_posit_mul_core.sv
// tb_posit_mul_core: directed and random operand pairs against a wide-arithmetic model.
// Define POSIT_MUL_ZERO_EN to also exercise the zero-operand path.
`timescale 1ns/1ps
module tb_posit_mul_core;
    localparam int BITS = 32;
    localparam int ES   = 3;
    localparam int LAT  = BITS + 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a_seed = '0;
    logic [2:0]  a_exp = '0;
    logic [31:0] a_frac = '0;
    logic [31:0] b_seed = '0;
    logic [2:0]  b_exp = '0;
    logic [31:0] b_frac = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_seed;
    logic [2:0]  out_exp;
    logic [31:0] out_frac;
    logic        out_inexact;
`ifdef POSIT_MUL_ZERO_EN
    logic        a_zero = 1'b0;
    logic        b_zero = 1'b0;
    logic        out_zero;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    posit_mul_core #(.BITS(BITS), .ES(ES)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a_seed(a_seed),
        .a_exp(a_exp),
        .a_frac(a_frac),
        .b_seed(b_seed),
        .b_exp(b_exp),
        .b_frac(b_frac),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_seed(out_seed),
        .out_exp(out_exp),
        .out_frac(out_frac),
        .out_inexact(out_inexact)
`ifdef POSIT_MUL_ZERO_EN
       ,.a_zero(a_zero),
        .b_zero(b_zero),
        .out_zero(out_zero)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Value = 2^scale * (1 + frac/2^32); product computed exactly, then truncated.
    task automatic model(
        input  logic [31:0] as, input logic [2:0] ae, input logic [31:0] af,
        input  logic [31:0] bs, input logic [2:0] be, input logic [31:0] bf,
        output logic [31:0] s, output logic [2:0] e,
        output logic [31:0] f, output logic inx
    );
        logic [65:0] p, rem, keep;
        longint      rs;
        int          l;
        p  = {33'b0, 1'b1, af} * {33'b0, 1'b1, bf};
        rs = longint'($signed(as)) * 8 + longint'(ae)
           + longint'($signed(bs)) * 8 + longint'(be);
        if (p >= (66'd1 << 65)) begin
            l  = 65;
            rs = rs + 1;
        end else begin
            l = 64;
        end
        rem  = p - (66'd1 << l);
        keep = rem >> (l - 29);
        f    = 32'(keep << 3);
        inx  = (keep << (l - 29)) != rem;
        s    = 32'(rs >>> 3);
        e    = rs[2:0];
    endtask

    task automatic do_op(
        input logic [31:0] as, input logic [2:0] ae, input logic [31:0] af,
        input logic [31:0] bs, input logic [2:0] be, input logic [31:0] bf,
        input bit az, input int hold
    );
        logic [31:0] xs, xf;
        logic [2:0]  xe;
        logic        xi;
        int          n;
        model(as, ae, af, bs, be, bf, xs, xe, xf, xi);
        if (az) begin
            xs = '0;
            xe = '0;
            xf = '0;
            xi = 1'b0;
        end
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready", 64'(in_ready), 64'd1);
        a_seed = as;
        a_exp  = ae;
        a_frac = af;
        b_seed = bs;
        b_exp  = be;
        b_frac = bf;
`ifdef POSIT_MUL_ZERO_EN
        a_zero = az;
        b_zero = 1'b0;
`endif
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        a_seed = $urandom;
        a_exp  = 3'($urandom);
        a_frac = $urandom;
        b_seed = $urandom;
        b_exp  = 3'($urandom);
        b_frac = $urandom;
`ifdef POSIT_MUL_ZERO_EN
        a_zero = 1'($urandom);
        b_zero = 1'($urandom);
`endif
        in_valid = !az;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 5) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        chk("latency", 64'(n), az ? 64'd1 : 64'(LAT));
        chk("seed", 64'(out_seed), 64'(xs));
        chk("exp", 64'(out_exp), 64'(xe));
        chk("frac", 64'(out_frac), 64'(xf));
        chk("inexact", 64'(out_inexact), 64'(xi));
`ifdef POSIT_MUL_ZERO_EN
        chk("zero", 64'(out_zero), 64'(az));
`endif
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_ready", 64'(in_ready), 64'd0);
            chk("hold_seed", 64'(out_seed), 64'(xs));
            chk("hold_exp", 64'(out_exp), 64'(xe));
            chk("hold_frac", 64'(out_frac), 64'(xf));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("release_valid", 64'(out_valid), 64'd0);
        chk("release_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        #12;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_seed", 64'(out_seed), 64'd0);
        chk("rst_exp", 64'(out_exp), 64'd0);
        chk("rst_frac", 64'(out_frac), 64'd0);
        chk("rst_inexact", 64'(out_inexact), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", 64'(in_ready), 64'd1);

        do_op(32'd0, 3'd0, 32'd0, 32'd0, 3'd0, 32'd0, 1'b0, 0);
        do_op(32'd0, 3'd0, 32'h8000_0000, 32'd0, 3'd0, 32'h8000_0000, 1'b0, 1);
        do_op(32'd0, 3'd7, 32'd0, 32'd0, 3'd1, 32'd0, 1'b0, 0);
        do_op(32'hFFFF_FFFF, 3'd0, 32'd0, 32'd0, 3'd3, 32'd0, 1'b0, 5);
        do_op(32'hFFFF_FFFF, 3'd0, 32'hC000_0000,
              32'd0, 3'd3, 32'h4000_0008, 1'b0, 0);

        // Abort an operation partway through the multiply.
        @(negedge clk);
        a_seed   = 32'd3;
        a_frac   = 32'h1234_5678;
        b_frac   = 32'h9ABC_DEF0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 64'(out_valid), 64'd0);
        chk("abort_seed", 64'(out_seed), 64'd0);
        chk("abort_exp", 64'(out_exp), 64'd0);
        chk("abort_frac", 64'(out_frac), 64'd0);
        chk("abort_inexact", 64'(out_inexact), 64'd0);
        #2;
        rst_n = 1'b1;
        n = 0;
        repeat (LAT + 10) begin
            @(posedge clk);
            #1;
            if (out_valid) n++;
        end
        chk("abort_no_valid", 64'(n), 64'd0);
        do_op(32'd2, 3'd5, 32'hF000_0000, 32'hFFFF_FFFD, 3'd6, 32'hFFFF_FFF8, 1'b0, 0);

`ifdef POSIT_MUL_ZERO_EN
        do_op(32'd5, 3'd2, 32'hABCD_0000, 32'd1, 3'd1, 32'h1111_1110, 1'b1, 2);
        do_op(32'd1, 3'd0, 32'h8000_0000, 32'd0, 3'd1, 32'h8000_0000, 1'b0, 0);
`endif

        for (int k = 0; k < 16; k++) begin
            do_op($urandom, 3'($urandom_range(0, 7)), $urandom & 32'hFFFF_FFF8,
                  $urandom, 3'($urandom_range(0, 7)), $urandom & 32'hFFFF_FFF8,
                  1'b0, int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
